// File: rtl/branch_pred_pkg.sv
// Shared constants and counter helpers for the pattern-history-table branch predictor.
package branch_pred_pkg;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Weakly-not-taken: one step below the taken threshold (0 for a 1-bit counter).
  function automatic int unsigned weak_nt(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  // Helpers work on a 4-bit container; callers truncate to their counter width.
  function automatic logic [3:0] sat_inc_dec(input logic [3:0] cnt, input logic taken,
                                             input int unsigned cnt_w);
    logic [3:0] max_v;
    max_v = 4'((32'd1 << cnt_w) - 32'd1);
    if (taken) return (cnt == max_v) ? cnt : cnt + 4'd1;
    else       return (cnt == 4'd0)  ? cnt : cnt - 4'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// One pattern-history entry: CNT_W-bit saturating up/down counter.
module sat_counter
  import branch_pred_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)  cnt <= CNT_W'(weak_nt(CNT_W));
    else if (en) cnt <= CNT_W'(sat_inc_dec(4'(cnt), taken, CNT_W));
  end

endmodule

// File: rtl/branch_pht_predictor.sv
// Bimodal / gshare branch predictor with non-speculative global history and
// resolved-branch / mispredict statistics.
module branch_pht_predictor
  import branch_pred_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int MODE    = MODE_BIMODAL,
  parameter int GHR_W   = 6,
  parameter int STAT_W  = 32,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       lookup_pc_i,
  output logic              predict_o,
  output logic [IDX_W-1:0]  predict_idx_o,
  input  logic              update_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_taken_i,
  input  logic              update_pred_i,
  output logic              mispredict_o,
  output logic [GHR_W-1:0]  ghr_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] miss_cnt_o
);

  logic [CNT_W-1:0] table_q [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] idx;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};
  assign base = lookup_pc_i[IDX_W+1:2];

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr;
    idx = (MODE == MODE_GSHARE) ? (base ^ ghr_ext) : base;
  end

  // No bypass: a same-cycle update to idx is seen from the next cycle on.
  assign predict_o     = table_q[idx][CNT_W-1];
  assign predict_idx_o = idx;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_tbl
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk_i),
      .rst_n (rst_i),
      .en    (update_i && (update_idx_i == IDX_W'(g))),
      .taken (update_taken_i),
      .cnt   (table_q[g])
    );
  end

  // Resolve stage: history shift, statistics and registered mispredict flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ghr          <= '0;
      mispredict_o <= 1'b0;
      branch_cnt_o <= '0;
      miss_cnt_o   <= '0;
    end else begin
      mispredict_o <= update_i & (update_pred_i ^ update_taken_i);
      if (update_i) begin
        // Truncation drops the oldest history bit.
        ghr <= GHR_W'({ghr, update_taken_i});
        if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + 1'b1;
        if ((update_pred_i != update_taken_i) && (miss_cnt_o != '1))
          miss_cnt_o <= miss_cnt_o + 1'b1;
      end
    end
  end

  assign ghr_o = ghr;

endmodule

// File: tb/tb_branch_pht_predictor.sv
// Directed bench: bimodal, gshare and narrow-statistics instances driven by one stream.
module tb_branch_pht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        upd;
  logic [5:0]  uidx;
  logic        utaken;
  logic        upred;

  logic        pred0, pred1, pred2;
  logic [5:0]  pidx0, pidx1, pidx2;
  logic        misp0, misp1, misp2;
  logic [5:0]  ghr0, ghr1, ghr2;
  logic [31:0] br0, miss0, br1, miss1;
  logic [3:0]  br2, miss2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_pht_predictor #(.MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred0), .predict_idx_o(pidx0),
    .update_i(upd), .update_idx_i(uidx), .update_taken_i(utaken), .update_pred_i(upred),
    .mispredict_o(misp0), .ghr_o(ghr0), .branch_cnt_o(br0), .miss_cnt_o(miss0));

  branch_pht_predictor #(.MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred1), .predict_idx_o(pidx1),
    .update_i(upd), .update_idx_i(uidx), .update_taken_i(utaken), .update_pred_i(upred),
    .mispredict_o(misp1), .ghr_o(ghr1), .branch_cnt_o(br1), .miss_cnt_o(miss1));

  branch_pht_predictor #(.MODE(0), .STAT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred2), .predict_idx_o(pidx2),
    .update_i(upd), .update_idx_i(uidx), .update_taken_i(utaken), .update_pred_i(upred),
    .mispredict_o(misp2), .ghr_o(ghr2), .branch_cnt_o(br2), .miss_cnt_o(miss2));

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [5:0]  uidx;
    logic        taken;
    logic        pred;
    logic        exp_predict;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic u, input logic [5:0] i, input logic t, input logic p);
    upd = u; uidx = i; utaken = t; upred = p;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0]  ghr_m;
    logic [31:0] br_m, miss_m;
    logic        misp_m;

    //          pc     upd uidx taken pred  exp_pred exp_idx
    vecs[0]  = '{32'h10, 0, 6'd4, 0, 0, 0, 6'd4};   // fresh entry is weakly not-taken
    vecs[1]  = '{32'h10, 1, 6'd4, 1, 0, 0, 6'd4};   // same-cycle update: old value 01
    vecs[2]  = '{32'h10, 1, 6'd4, 1, 1, 1, 6'd4};   // 10
    vecs[3]  = '{32'h10, 1, 6'd4, 1, 1, 1, 6'd4};   // 11, stays 11
    vecs[4]  = '{32'h10, 1, 6'd4, 0, 1, 1, 6'd4};   // 11 -> 10
    vecs[5]  = '{32'h10, 1, 6'd4, 0, 0, 1, 6'd4};   // 10 -> 01
    vecs[6]  = '{32'h10, 0, 6'd4, 0, 0, 0, 6'd4};
    vecs[7]  = '{32'h14, 1, 6'd4, 1, 1, 0, 6'd5};   // neighbour untouched
    vecs[8]  = '{32'h10, 0, 6'd0, 0, 0, 1, 6'd4};
    vecs[9]  = '{32'h10, 1, 6'd4, 0, 0, 1, 6'd4};
    vecs[10] = '{32'h10, 0, 6'd0, 0, 0, 0, 6'd4};

    pc = 32'h10;
    rst = 1'b0;
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #2;
    chk("reset_predict", {31'd0, pred0}, 32'd0);
    chk("reset_idx", {26'd0, pidx0}, 32'd4);
    chk("reset_branch_cnt", br0, 32'd0);
    chk("reset_miss_cnt", miss0, 32'd0);
    chk("reset_ghr", {26'd0, ghr0}, 32'd0);
    chk("reset_mispredict", {31'd0, misp0}, 32'd0);

    ghr_m = '0; br_m = '0; miss_m = '0;
    for (int i = 0; i < 11; i++) begin
      pc = vecs[i].pc;
      drive(vecs[i].upd, vecs[i].uidx, vecs[i].taken, vecs[i].pred);
      #2;
      chk($sformatf("vec%0d_predict", i), {31'd0, pred0}, {31'd0, vecs[i].exp_predict});
      chk($sformatf("vec%0d_idx", i), {26'd0, pidx0}, {26'd0, vecs[i].exp_idx});
      tick();
      misp_m = vecs[i].upd & (vecs[i].pred ^ vecs[i].taken);
      if (vecs[i].upd) begin
        ghr_m = {ghr_m[4:0], vecs[i].taken};
        br_m++;
        if (vecs[i].pred != vecs[i].taken) miss_m++;
      end
      chk($sformatf("vec%0d_ghr", i), {26'd0, ghr0}, {26'd0, ghr_m});
      chk($sformatf("vec%0d_branch_cnt", i), br0, br_m);
      chk($sformatf("vec%0d_miss_cnt", i), miss0, miss_m);
      chk($sformatf("vec%0d_mispredict", i), {31'd0, misp0}, {31'd0, misp_m});
    end

    // Saturate entry 4, then reset while an update is presented.
    pc = 32'h10;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd4, 1'b1, 1'b0);
      tick();
    end
    rst = 1'b0;
    drive(1'b1, 6'd4, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    #2;
    chk("midreset_predict", {31'd0, pred0}, 32'd0);
    chk("midreset_ghr", {26'd0, ghr0}, 32'd0);
    chk("midreset_branch_cnt", br0, 32'd0);
    chk("midreset_miss_cnt", miss0, 32'd0);
    chk("midreset_mispredict", {31'd0, misp0}, 32'd0);
    drive(1'b1, 6'd4, 1'b1, 1'b1);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    #2;
    chk("midreset_one_step_to_wt", {31'd0, pred0}, 32'd1);

    // Mispredict flag and counters.
    do_reset();
    drive(1'b1, 6'd4, 1'b0, 1'b1);
    tick();
    drive(1'b1, 6'd4, 1'b0, 1'b0);
    chk("miss_flag", {31'd0, misp0}, 32'd1);
    chk("miss_cnt_1", miss0, 32'd1);
    chk("miss_branch_cnt_1", br0, 32'd1);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("hit_flag_clear", {31'd0, misp0}, 32'd0);
    chk("hit_miss_cnt_1", miss0, 32'd1);
    chk("hit_branch_cnt_2", br0, 32'd2);
    tick();
    chk("idle_flag_clear", {31'd0, misp0}, 32'd0);

    // Gshare index: history 110 XOR base 8.
    do_reset();
    drive(1'b1, 6'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 6'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 6'd3, 1'b0, 1'b0);
    tick();
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    pc = 32'h20;
    #2;
    chk("gshare_ghr", {26'd0, ghr1}, 32'd6);
    chk("gshare_idx", {26'd0, pidx1}, 32'd14);
    chk("gshare_predict", {31'd0, pred1}, 32'd0);
    chk("bimodal_idx_pc20", {26'd0, pidx0}, 32'd8);

    // Statistics saturation on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 6'd0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b0);
    chk("stat4_miss_sat", {28'd0, miss2}, 32'd15);
    chk("stat4_branch_sat", {28'd0, br2}, 32'd15);
    chk("stat32_miss_20", miss0, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pht_predictor.md
Name: branch_pht_predictor

Overview:
- Parametrised successor to the pipeline's single-state branch predictor: a table of saturating counters that gives per-branch taken/not-taken predictions.
- Supports two modes: bimodal (indexed by PC) and gshare (PC XOR global history).
- Lookup is combinational in ID. The pipeline carries the lookup index and prediction with the branch into EX, and they come back on the resolve/update port when the branch executes.
- Also keeps resolved-branch and mispredict statistics counters.

Parameters:
ENTRIES, 64, table depth; power of two, 4..1024; IDX_W = clog2(ENTRIES)
CNT_W, 2, saturating counter width; 1..4
MODE, 0, 0 = bimodal, 1 = gshare
GHR_W, 6, global history length; 1..IDX_W; ignored when MODE = 0
STAT_W, 32, statistics counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
lookup_pc_i  in  32  PC of the instruction in ID
predict_o  out  1  predicted taken (combinational)
predict_idx_o  out  IDX_W  table index used for predict_o; carried to EX by the pipeline
update_i  in  1  a branch resolves in EX this cycle
update_idx_i  in  IDX_W  index returned from the pipeline for that branch
update_taken_i  in  1  actual outcome (ALU zero for beq)
update_pred_i  in  1  prediction that was made for that branch
mispredict_o  out  1  registered; high for one cycle after an update whose prediction was wrong
ghr_o  out  GHR_W  current global history (debug)
branch_cnt_o  out  STAT_W  number of resolved branches
miss_cnt_o  out  STAT_W  number of mispredicts

Behaviour:
Reset (rst_i = 0 sampled at a rising edge):
- Every counter is set to weakly-not-taken, 2^(CNT_W-1)-1 (2'b01 for CNT_W = 2; 0 for CNT_W = 1).
- ghr = 0, mispredict_o = 0, branch_cnt_o = 0, miss_cnt_o = 0.
- Reset wins over a simultaneous update.

Index:
- base = lookup_pc_i[IDX_W+1:2].
- MODE 0: idx = base.
- MODE 1: idx = base XOR zero-extended ghr.

Prediction (combinational, zero latency):
- predict_o = MSB of table[idx]; predict_idx_o = idx.

Update (takes effect at the clock edge where update_i = 1):
- taken: table[update_idx_i] increments, saturating at 2^CNT_W-1.
- not taken: it decrements, saturating at 0.
- Table is unchanged when update_i = 0.

GHR:
- Non-speculative; shifts only on an update: ghr <= {ghr[GHR_W-2:0], update_taken_i}. The oldest bit is dropped.
- Because the index is carried with the branch, a GHR change between lookup and resolve cannot cause a wrong-entry update.
- In MODE 0 the GHR still shifts, for debug only.

Statistics (registered):
- branch_cnt_o increments on every update.
- miss_cnt_o increments when update_pred_i != update_taken_i.
- Both saturate at all-ones; there is no wrap.
- mispredict_o <= update_i & (update_pred_i ^ update_taken_i), one-cycle latency.

Simultaneous lookup and update on the same index:
- predict_o reflects the pre-update counter value; there is no bypass.
- The new value is visible from the next cycle.

Per-counter state machine (CNT_W = 2):
- States SNT = 00, WNT = 01, WT = 10, ST = 11.
- Transitions move by ±1 and saturate at the ends.
- Predict taken in WT and ST.

Other rules:
- update_idx_i is used verbatim; the block does not range-check it (always in range by construction).
- Pipeline stalls or flushes that drop a branch before EX must simply not assert update_i. The table and GHR stay consistent.

Decomposition:
- Shared package, branch_pred_pkg:
  - constants for MODE_BIMODAL = 0 and MODE_GSHARE = 1;
  - a function returning the weak-not-taken reset value for CNT_W;
  - a function sat_inc_dec(cnt, taken).
- One natural sub-module, sat_counter: a CNT_W-bit saturating counter with inc/dec enable and sync active-low reset. It is instantiated ENTRIES times via generate. Alternatively the table may be a flat register array using the package function; the sub-module is preferred.

Test Plan:
1. Reset, then look up pc = 0x0000_0010 in MODE 0:
   - predict_o = 0, predict_idx_o = 4; both counters = 0; ghr_o = 0.
2. Three updates on idx 4 with taken = 1:
   - counter goes 01 → 10 → 11 → 11 (saturates); predict_o for pc 0x10 becomes 1 after the first update.
   - Then two not-taken updates: counter 11 → 10 → 01; predict_o = 0.
3. Same-cycle lookup and update on idx 4 at counter 01, taken:
   - predict_o = 0 in that cycle and 1 in the next cycle.
4. MODE 1, GHR_W = 6, ENTRIES = 64; resolve taken, taken, not-taken (ghr = 6'b000110), then look up pc = 0x0000_0020:
   - predict_idx_o = 8 XOR 6 = 14.
5. Mispredict: update with pred = 1, taken = 0:
   - mispredict_o = 1 exactly one cycle later; miss_cnt_o = 1, branch_cnt_o = 1.
   - A following correct update leaves miss_cnt_o at 1 and drives mispredict_o to 0.
6. Reset mid-run, with counters saturated and stats nonzero:
   - rst_i = 0 held one cycle while update_i = 1.
   - All counters return to 01; ghr, stats and mispredict_o are 0; the update is ignored.
   - STAT_W = 4 variant: 20 mispredicts → miss_cnt_o stays at 15.
